field_serializer: RTL and testbench
===================================

FIELD_SERIALIZER -- requirements
Module: field_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port `reset`, input, 1 bit: synchronous, active-high.
REQ-004 Port `entry_in`, input, TABLE_ENTRY: descriptor of the current field. Fields used: `field_id[28:0]`, `offset[63:0]`, `nested`, `field_type[2:0]`.
REQ-005 Port `entry_valid`, input, 1 bit: `entry_in` and `cpp_base_addr` are valid.
REQ-006 Port `cpp_base_addr`, input, 64 bits: base address of the C++ object that owns the field.
REQ-007 Port `ser_ready`, output, 1 bit: high only in IDLE; an entry is accepted when `entry_valid` and `ser_ready` are both high.
REQ-008 Port `ser_done`, output, 1 bit: one-cycle pulse; the entry is fully emitted.
REQ-009 Port `mem_req`, output, 1 bit: one-cycle read request pulse.
REQ-010 Port `mem_addr`, output, 64 bits: read address; held stable until `mem_rvalid`.
REQ-011 Port `mem_rdata`, input, 64 bits: read data; valid when `mem_rvalid` is high.
REQ-012 Port `mem_rvalid`, input, 1 bit: read response strobe; arrives any cycle after `mem_req`.
REQ-013 Port `out_byte`, output, 8 bits: serialized protobuf byte.
REQ-014 Port `out_byte_valid`, output, 1 bit: `out_byte` is valid.
REQ-015 Port `out_byte_ready`, input, 1 bit: downstream accepts the byte.

Function
REQ-016 States SHALL be IDLE, TAG, MREQ, MWAIT, VALUE, DONE.
REQ-017 IDLE:
- On accept, latch `entry_in` and `cpp_base_addr`.
- If `field_id`==0 (end-of-object marker), go to DONE with no bytes and no memory access.
- Otherwise, go to TAG.
REQ-018 Tag value = {field_id, wt}, 32 bits. `wt` is:
- 2 if `nested`;
- else 0 for `field_type`==0 (varint);
- 1 for `field_type`==1 (fixed64);
- 5 for `field_type`==5 (fixed32).
Any other `field_type` SHALL be treated as varint.
REQ-019 Varint encoding: emit 7-bit groups LSB first; MSB=1 on every byte except the last. Tag is 1–5 bytes; 64-bit value is 1–10 bytes. A value of 0 emits the single byte 0x00.
REQ-020 TAG: emit tag bytes. After the last tag byte transfers:
- go to DONE if `nested`;
- else go to MREQ.
REQ-021 MREQ: assert `mem_req` for one cycle with `mem_addr` = latched base + offset (mod 2^64), then go to MWAIT.
REQ-022 MWAIT: on `mem_rvalid`, latch `mem_rdata` and go to VALUE. Only one request SHALL be outstanding at a time.
REQ-023 VALUE: emit the payload, then go to DONE after the last byte transfers:
- varint: per REQ-019;
- fixed64: 8 bytes, little-endian;
- fixed32: `mem_rdata[31:0]`, 4 bytes, little-endian.
REQ-024 Byte handshake:
- A transfer occurs when `out_byte_valid` and `out_byte_ready` are both high.
- `out_byte` SHALL be held stable while valid and not ready.
- One byte per cycle maximum; no bubbles between bytes of the same entry when ready is held high.
REQ-025 DONE: pulse `ser_done` for one cycle, then return to IDLE. `ser_ready` SHALL be low in DONE, so the stale entry still presented is not re-accepted. A new entry may be accepted the cycle after DONE.
REQ-026 Latency:
- First tag byte valid 1 cycle after accept.
- `mem_req` the cycle after the last tag byte transfers.
- First value byte valid the cycle after `mem_rvalid`.
REQ-027 Inputs are ignored outside their relevant states:
- `mem_rvalid` outside MWAIT;
- `entry_valid` outside IDLE;
- `out_byte_ready` when `out_byte_valid` is low.

Reset
REQ-028 While `reset` is high, the block SHALL be in IDLE and the following SHALL be 0: `ser_ready`, `ser_done`, `mem_req`, `out_byte_valid`, `out_byte`, `mem_addr`. `ser_ready` SHALL rise the cycle after `reset` deasserts.
REQ-029 Reset asserted in any state SHALL abort the entry with no `ser_done`. A late `mem_rvalid` arriving after reset SHALL be discarded.

Verification
REQ-030 Varint field. Stimulus: base 0x100, field_id=1, type 0, offset 8, `mem_rdata`=150, ready held high. Required: `mem_addr`=0x108; bytes 0x08, 0x96, 0x01; one `ser_done` pulse.
REQ-031 Fixed32 field. Stimulus: field_id=2, type 5, `mem_rdata`=0x12345678. Required: bytes 0x15, 0x78, 0x56, 0x34, 0x12.
REQ-032 Multi-byte tag, zero value. Stimulus: field_id=16, type 0, `mem_rdata`=0. Required: bytes 0x80, 0x01, 0x00.
REQ-033 Nested and end-of-object entries. Stimulus: nested field_id=3, then an entry with field_id=0. Required: nested entry emits byte 0x1A only, with no `mem_req`; field_id=0 entry emits no bytes and `ser_done` 1 cycle after accept.
REQ-034 Backpressure. Stimulus: `out_byte_ready` low for 3 cycles mid-value. Required: `out_byte` and `out_byte_valid` held constant; no byte lost or duplicated.
REQ-035 Reset mid-operation. Stimulus: `reset` in VALUE, followed by a late `mem_rvalid`. Required: outputs 0; no `ser_done`; IDLE with `ser_ready`=1 the cycle after deassert; the next entry is serialized correctly.

Source files
------------

// File: rtl/field_serializer.sv
// Protobuf field serializer: emits tag, fetches the field from memory,
// then emits the value as varint or fixed32/fixed64 bytes.
package field_serializer_pkg;
  typedef struct packed {
    logic [28:0] field_id;
    logic [63:0] offset;
    logic        nested;
    logic [2:0]  field_type;
  } table_entry_t;
endpackage

module field_serializer
  import field_serializer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  table_entry_t entry_in,
  input  logic         entry_valid,
  input  logic [63:0]  cpp_base_addr,
  output logic         ser_ready,
  output logic         ser_done,
  output logic         mem_req,
  output logic [63:0]  mem_addr,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_rvalid,
  output logic [7:0]   out_byte,
  output logic         out_byte_valid,
  input  logic         out_byte_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_TAG, S_MREQ, S_MWAIT, S_VALUE, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] sh_q, sh_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  wt_q, wt_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        fixed;
  logic        last;
  logic        xfer;
  logic [2:0]  wt_in;

  // Fixed encodings count bytes; varint ends when no bits remain above the group.
  assign fixed = (state_q == S_VALUE) &&
                 ((wt_q == 3'd1) || (wt_q == 3'd5));
  assign last  = fixed ? (cnt_q == 3'd0) : (sh_q[63:7] == 57'd0);

  assign ser_ready      = ~reset & (state_q == S_IDLE);
  assign ser_done       = ~reset & (state_q == S_DONE);
  assign mem_req        = ~reset & (state_q == S_MREQ);
  assign mem_addr       = reset ? 64'd0 : addr_q;
  assign out_byte_valid = ~reset &
                          ((state_q == S_TAG) | (state_q == S_VALUE));
  assign xfer           = out_byte_valid & out_byte_ready;

  // Current byte comes straight from the shift register, so it holds under stall.
  always_comb begin
    out_byte = 8'd0;
    if (out_byte_valid) begin
      out_byte = fixed ? sh_q[7:0] : {~last, sh_q[6:0]};
    end
  end

  // Wire type of the incoming entry; nested overrides field_type.
  always_comb begin
    wt_in = 3'd0;
    if (entry_in.nested) begin
      wt_in = 3'd2;
    end else if (entry_in.field_type == 3'd1) begin
      wt_in = 3'd1;
    end else if (entry_in.field_type == 3'd5) begin
      wt_in = 3'd5;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    wt_d    = wt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (entry_valid) begin
          wt_d   = wt_in;
          addr_d = cpp_base_addr + entry_in.offset;
          sh_d   = {32'd0, entry_in.field_id, wt_in};
          if (entry_in.field_id == 29'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_TAG;
          end
        end
      end
      S_TAG: begin
        if (xfer) begin
          if (last) begin
            state_d = (wt_q == 3'd2) ? S_DONE : S_MREQ;
          end else begin
            sh_d = sh_q >> 7;
          end
        end
      end
      S_MREQ: begin
        state_d = S_MWAIT;
      end
      S_MWAIT: begin
        if (mem_rvalid) begin
          if (wt_q == 3'd5) begin
            sh_d  = {32'd0, mem_rdata[31:0]};
            cnt_d = 3'd3;
          end else begin
            sh_d  = mem_rdata;
            cnt_d = 3'd7;
          end
          state_d = S_VALUE;
        end
      end
      S_VALUE: begin
        if (xfer) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            sh_d  = fixed ? (sh_q >> 8) : (sh_q >> 7);
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= 64'd0;
      addr_q  <= 64'd0;
      wt_q    <= 3'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      wt_q    <= wt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_field_serializer.sv
// Testbench for field_serializer: directed vector table, backpressure,
// reset abort, and randomized entries against a protobuf encoding model.
module tb_field_serializer;
  import field_serializer_pkg::*;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [28:0]       fid;
    logic [2:0]        typ;
    logic              nst;
    logic [63:0]       base;
    logic [63:0]       off;
    logic [63:0]       rd;
    logic [63:0]       addr;
    int                n;
    logic [0:15][7:0]  b;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  table_entry_t entry_in;
  logic         entry_valid;
  logic [63:0]  cpp_base_addr;
  logic         ser_ready;
  logic         ser_done;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic [63:0]  mem_rdata;
  logic         mem_rvalid;
  logic [7:0]   out_byte;
  logic         out_byte_valid;
  logic         out_byte_ready;

  int n_chk = 0;
  int n_pass = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  field_serializer dut (
    .clk           (clk),
    .reset         (reset),
    .entry_in      (entry_in),
    .entry_valid   (entry_valid),
    .cpp_base_addr (cpp_base_addr),
    .ser_ready     (ser_ready),
    .ser_done      (ser_done),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .out_byte      (out_byte),
    .out_byte_valid(out_byte_valid),
    .out_byte_ready(out_byte_ready)
  );

  always @(negedge clk) if (ser_done) done_seen++;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction

  function automatic bq_t varint(logic [63:0] v);
    bq_t q;
    logic [63:0] r;
    logic [7:0] b;
    r = v;
    do begin
      b = 8'(r % 128);
      r = r / 128;
      q.push_back((r != 0) ? (b + 8'd128) : b);
    end while (r != 0);
    return q;
  endfunction

  function automatic int wt_of(logic [2:0] typ, logic nst);
    if (nst) return 2;
    if (typ == 3'd1) return 1;
    if (typ == 3'd5) return 5;
    return 0;
  endfunction

  function automatic bq_t model(logic [28:0] fid, logic [2:0] typ,
                                logic nst, logic [63:0] rd);
    bq_t q;
    int wt;
    if (fid == 0) return q;
    wt = wt_of(typ, nst);
    q = varint(64'(fid) * 8 + 64'(wt));
    if (nst) return q;
    if (wt == 1) for (int i = 0; i < 8; i++) q.push_back(8'(rd >> (8 * i)));
    else if (wt == 5) for (int i = 0; i < 4; i++) q.push_back(8'(rd >> (8 * i)));
    else q = {q, varint(rd)};
    return q;
  endfunction

  function automatic vec_t mk(logic [28:0] fid, logic [2:0] typ, logic nst,
                              logic [63:0] base, logic [63:0] off,
                              logic [63:0] rd, logic [63:0] addr, int n,
                              logic [0:15][7:0] b);
    vec_t v;
    v.fid = fid; v.typ = typ; v.nst = nst; v.base = base; v.off = off;
    v.rd = rd; v.addr = addr; v.n = n; v.b = b;
    return v;
  endfunction

  // mode 0: ready high, 1: random ready + stray rvalid, 2: 3-cycle stall mid-value
  task automatic run_entry(input logic [28:0] fid, input logic [2:0] typ,
                           input logic nst, input logic [63:0] base,
                           input logic [63:0] off, input logic [63:0] rd,
                           input logic [63:0] exp_addr, input bq_t exp,
                           input int mode, input string nm);
    bq_t got;
    int reqs = 0, dones = 0, cyc = 0, lat = 0, stall_left = 3, bad = 0;
    int acc_cyc = -1, first_v = -1, done_cyc = -1, tag_end = -1;
    int req_cyc = -1, rv_cyc = -1, val_first = -1, ntg = 0;
    bit pend = 0, stalled = 0, exp_mem;
    logic [7:0] hold_b = 8'd0;
    logic [63:0] addr_seen = 64'd0;
    if (fid != 0) ntg = varint(64'(fid) * 8 + 64'(wt_of(typ, nst))).size();
    exp_mem = (fid != 0) && !nst;
    entry_in.field_id = fid;
    entry_in.offset = off;
    entry_in.nested = nst;
    entry_in.field_type = typ;
    cpp_base_addr = base;
    entry_valid = 1'b1;
    while (dones == 0 && cyc < 300) begin
      if (acc_cyc < 0 && ser_ready) acc_cyc = cyc;
      mem_rvalid = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mem_req) begin
        reqs++; addr_seen = mem_addr; req_cyc = cyc;
        pend = 1; lat = $urandom_range(1, 4);
      end else if (pend) begin
        lat--;
        if (lat == 0) begin
          check({nm, " addr_hold"}, mem_addr, addr_seen);
          mem_rvalid = 1'b1; mem_rdata = rd; pend = 0; rv_cyc = cyc;
        end
      end else if (mode == 1 && $urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b1;
      end
      case (mode)
        0: out_byte_ready = 1'b1;
        1: out_byte_ready = ($urandom_range(0, 2) != 0);
        default: begin
          out_byte_ready = !(got.size() == ntg + 2 && stall_left > 0 && out_byte_valid);
          if (!out_byte_ready) stall_left--;
        end
      endcase
      if (out_byte_valid) begin
        if (first_v < 0) first_v = cyc;
        if (rv_cyc >= 0 && val_first < 0) val_first = cyc;
        if (stalled) check({nm, " byte_hold"}, 64'(out_byte), 64'(hold_b));
        if (out_byte_ready) begin
          got.push_back(out_byte);
          if (got.size() == ntg) tag_end = cyc;
        end
        stalled = !out_byte_ready;
        hold_b = out_byte;
      end else if (stalled) begin
        check({nm, " valid_hold"}, 0, 1);
        stalled = 0;
      end
      if (ser_done) begin
        dones++; done_cyc = cyc; entry_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    entry_valid = 1'b0;
    mem_rvalid = 1'b0;
    check({nm, " done"}, dones, 1);
    check({nm, " nbytes"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i >= got.size() || got[i] !== exp[i]) bad++;
    check({nm, " bad_bytes"}, bad, 0);
    check({nm, " mem_reqs"}, reqs, 64'(exp_mem));
    if (exp_mem) begin
      check({nm, " mem_addr"}, addr_seen, exp_addr);
      check({nm, " lat_req"}, req_cyc - tag_end, 1);
      check({nm, " lat_val"}, val_first - rv_cyc, 1);
    end
    if (fid == 0) check({nm, " lat_done"}, done_cyc - acc_cyc, 1);
    else check({nm, " lat_tag"}, first_v - acc_cyc, 1);
    check({nm, " post_done"}, {ser_ready, ser_done, out_byte_valid}, 3'b100);
  endtask

  vec_t tbl[10];

  initial begin
    bq_t e;
    logic [28:0] fid;
    logic [2:0] typ;
    logic nst;
    logic [63:0] base, off, rd;
    bit seen;
    int d0;

    tbl[0] = mk(29'd1, 3'd0, 1'b0, 64'h100, 64'h8, 64'd150, 64'h108, 3,
                {8'h08, 8'h96, 8'h01, 104'h0});
    tbl[1] = mk(29'd2, 3'd5, 1'b0, 64'h2000, 64'h10, 64'hDEADBEEF_12345678,
                64'h2010, 5, {8'h15, 8'h78, 8'h56, 8'h34, 8'h12, 88'h0});
    tbl[2] = mk(29'd16, 3'd0, 1'b0, 64'h300, 64'h0, 64'd0, 64'h300, 3,
                {8'h80, 8'h01, 8'h00, 104'h0});
    tbl[3] = mk(29'd3, 3'd0, 1'b1, 64'h400, 64'h4, 64'd9, 64'h404, 1,
                {8'h1A, 120'h0});
    tbl[4] = mk(29'd0, 3'd0, 1'b0, 64'h500, 64'h8, 64'd7, 64'h508, 0, 128'h0);
    tbl[5] = mk(29'd1, 3'd1, 1'b0, 64'h1000, 64'h8, 64'h01020304_05060708,
                64'h1008, 9, {8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04,
                              8'h03, 8'h02, 8'h01, 56'h0});
    tbl[6] = mk(29'h1FFFFFFF, 3'd0, 1'b0, 64'h600, 64'h0, {64{1'b1}},
                64'h600, 15, {8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'h0F,
                              {9{8'hFF}}, 8'h01, 8'h00});
    tbl[7] = mk(29'd5, 3'd3, 1'b0, 64'h700, 64'h1, 64'd1, 64'h701, 2,
                {8'h28, 8'h01, 112'h0});
    tbl[8] = mk(29'd2, 3'd0, 1'b0, 64'hFFFFFFFF_FFFFFFF0, 64'h20, 64'h7F,
                64'h10, 2, {8'h10, 8'h7F, 112'h0});
    tbl[9] = mk(29'd4, 3'd1, 1'b1, 64'h800, 64'h0, 64'd3, 64'h800, 1,
                {8'h22, 120'h0});

    reset = 1'b1; entry_valid = 1'b0; entry_in = '0; cpp_base_addr = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; out_byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {ser_ready, ser_done, mem_req, out_byte_valid, out_byte}, 0);
    check("reset_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", ser_ready, 1);

    for (int i = 0; i < 10; i++) begin
      e = {};
      for (int j = 0; j < tbl[i].n; j++) e.push_back(tbl[i].b[j]);
      run_entry(tbl[i].fid, tbl[i].typ, tbl[i].nst, tbl[i].base, tbl[i].off,
                tbl[i].rd, tbl[i].addr, e, 0, $sformatf("vec%0d", i));
    end

    e = {};
    for (int j = 0; j < tbl[1].n; j++) e.push_back(tbl[1].b[j]);
    run_entry(tbl[1].fid, tbl[1].typ, 1'b0, tbl[1].base, tbl[1].off,
              tbl[1].rd, tbl[1].addr, e, 2, "stall");

    // Reset while in VALUE, then a late read response.
    d0 = done_seen;
    entry_in.field_id = 29'd1; entry_in.offset = 64'h40;
    entry_in.nested = 1'b0; entry_in.field_type = 3'd1;
    cpp_base_addr = 64'h5000; entry_valid = 1'b1; out_byte_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    check("rst_seq_req", seen, 1);
    entry_valid = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'h1122334455667788;
    @(negedge clk);
    mem_rvalid = 1'b0; out_byte_ready = 1'b0;
    check("rst_seq_value", {out_byte_valid, out_byte}, 9'h188);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {ser_ready, ser_done, mem_req, out_byte_valid, out_byte}, 0);
    check("rst_mid_addr", mem_addr, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst_after", {ser_ready, out_byte_valid, mem_req, ser_done}, 4'b1000);
    check("rst_no_done", done_seen - d0, 0);
    run_entry(tbl[0].fid, 3'd0, 1'b0, 64'h100, 64'h8, 64'd150, 64'h108,
              model(29'd1, 3'd0, 1'b0, 64'd150), 0, "post_rst");

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) fid = 29'd0;
      else if ($urandom_range(0, 1) == 1) fid = 29'($urandom_range(1, 40));
      else fid = 29'($urandom);
      typ = 3'($urandom_range(0, 7));
      nst = ($urandom_range(0, 7) == 0);
      base = {$urandom, $urandom};
      off = {$urandom, $urandom};
      rd = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_entry(fid, typ, nst, base, off, rd, base + off,
                model(fid, typ, nst, rd), 1, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
